// File: rtl/p10_prm_regfile_if.sv
// Shared parameter-metadata types plus the request/response bus of the parameter register file.
// Latency: none (types and wiring only).
// Backpressure: req_valid/req_ready on the request side, rsp_valid/rsp_ready on the response side.
//
// p10_pkg_common : prm_entry_t metadata record, rights encoding, opcode and status codes.
// p10_prm_regfile_if ports (master = command parser, slave = register file):
//   req_valid/req_ready, req_op[1:0], req_ch, req_addr, req_data  -- one request
//   rsp_valid/rsp_ready, rsp_status[2:0], rsp_data, rsp_entry       -- one response

package p10_pkg_common;

  // bit0 = readable, bit1 = writable
  typedef enum logic [1:0] {
    PRM_NONE = 2'd0,
    PRM_RO   = 2'd1,
    PRM_WO   = 2'd2,
    PRM_RW   = 2'd3
  } prm_rights_t;

  typedef struct packed {
    logic [63:0] name;     // 8 ASCII chars, space padded
    logic [31:0] min_val;
    logic [31:0] max_val;
    logic [23:0] units;    // 3 ASCII chars, space padded
    prm_rights_t rights;
    logic        is_exec;  // action parameter: EXEC only, never stores a value
  } prm_entry_t;

  typedef enum logic [1:0] {
    OP_READ  = 2'd0,
    OP_WRITE = 2'd1,
    OP_EXEC  = 2'd2,
    OP_INFO  = 2'd3
  } prm_op_t;

  typedef enum logic [2:0] {
    ST_OK       = 3'd0,
    ST_BAD_ADDR = 3'd1,
    ST_BAD_CH   = 3'd2,
    ST_DENIED   = 3'd3,
    ST_RANGE    = 3'd4,
    ST_BAD_OP   = 3'd5
  } prm_status_t;

endpackage

interface p10_prm_regfile_if #(
  parameter int PRM_COUNT = 8,
  parameter int CH_COUNT  = 2,
  parameter int DATA_W    = 32
);
  localparam int AW = $clog2(PRM_COUNT + 1);
  localparam int CW = $clog2(CH_COUNT + 1);

  logic                      req_valid;
  logic                      req_ready;
  logic [1:0]                req_op;
  logic [CW-1:0]             req_ch;
  logic [AW-1:0]             req_addr;
  logic [DATA_W-1:0]         req_data;

  logic                      rsp_valid;
  logic                      rsp_ready;
  logic [2:0]                rsp_status;
  logic [DATA_W-1:0]         rsp_data;
  p10_pkg_common::prm_entry_t rsp_entry;

  modport master (
    output req_valid, req_op, req_ch, req_addr, req_data, rsp_ready,
    input  req_ready, rsp_valid, rsp_status, rsp_data, rsp_entry
  );

  modport slave (
    input  req_valid, req_op, req_ch, req_addr, req_data, rsp_ready,
    output req_ready, rsp_valid, rsp_status, rsp_data, rsp_entry
  );
endinterface

// File: rtl/p10_prm_regfile.sv
// Multi-channel parameter register file with metadata ROM, rights/range checks and exec strobes.
// Latency: rsp_valid is high in the 3rd cycle after the accepting cycle; 1 request per 4 cycles.
// Backpressure: one request in flight; req_ready low until the response handshake completes.
//
// Ports: clk, rst_n (async active-low); bus (slave modport of p10_prm_regfile_if);
//   exec_pulse[ch*PRM_COUNT+addr] 1-cycle strobes; values flat live-value bus, same index
//   order, DATA_W bits per entry; init_done high once the post-reset min-value walk is over.

module p10_prm_regfile #(
  parameter int PRM_COUNT = 8,
  parameter int CH_COUNT  = 2,
  parameter int DATA_W    = 32
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  p10_prm_regfile_if.slave                     bus,
  output logic [CH_COUNT*PRM_COUNT-1:0]        exec_pulse,
  output logic [CH_COUNT*PRM_COUNT*DATA_W-1:0] values,
  output logic                                 init_done
);
  import p10_pkg_common::*;

  localparam int AW  = $clog2(PRM_COUNT + 1);
  localparam int CW  = $clog2(CH_COUNT + 1);
  localparam int IW  = (PRM_COUNT > 1) ? $clog2(PRM_COUNT) : 1;
  localparam int CIW = (CH_COUNT > 1) ? $clog2(CH_COUNT) : 1;
  localparam int ICW = $clog2(2 * PRM_COUNT);
  localparam logic [AW-1:0]  ADDR_LIM  = AW'(PRM_COUNT);
  localparam logic [CW-1:0]  CH_LIM    = CW'(CH_COUNT);
  localparam logic [ICW-1:0] INIT_LAST = ICW'(2 * PRM_COUNT - 1);

  typedef enum logic [2:0] {S_INIT, S_IDLE, S_FETCH, S_CHECK, S_RESP} state_t;

  function automatic prm_entry_t mk(input logic [63:0] nm, input logic [31:0] lo,
                                    input logic [31:0] hi, input logic [23:0] un,
                                    input prm_rights_t rt, input logic ex);
    prm_entry_t e;
    e.name = nm; e.min_val = lo; e.max_val = hi; e.units = un; e.rights = rt; e.is_exec = ex;
    return e;
  endfunction

  function automatic prm_entry_t rom_lookup(input logic [IW-1:0] a);
    prm_entry_t e;
    case (int'(a))
      0:       e = mk("freq    ", 32'd0,   32'd100000, "Hz ", PRM_RW, 1'b0);
      1:       e = mk("duty    ", 32'd0,   32'd50,     "pct", PRM_RW, 1'b0);
      2:       e = mk("phase   ", 32'd0,   32'd359,    "deg", PRM_RW, 1'b0);
      3:       e = mk("deadtime", 32'd10,  32'd1000,   "ns ", PRM_RW, 1'b0);
      4:       e = mk("fw_ver  ", 32'd258, 32'd258,    "ver", PRM_RO, 1'b0);
      5:       e = mk("key     ", 32'd0,   32'd65535,  "   ", PRM_WO, 1'b0);
      6:       e = mk("start   ", 32'd0,   32'd0,      "   ", PRM_RW, 1'b1);
      7:       e = mk("stop    ", 32'd0,   32'd0,      "   ", PRM_RW, 1'b1);
      default: e = '0;
    endcase
    return e;
  endfunction

  state_t                                         state_q, state_d;
  logic [ICW-1:0]                                 init_cnt_q, init_cnt_d;
  logic                                           init_done_q, init_done_d;
  logic [1:0]                                     op_q, op_d;
  logic [CW-1:0]                                  ch_q, ch_d;
  logic [AW-1:0]                                  addr_q, addr_d;
  logic [DATA_W-1:0]                              data_q, data_d;
  prm_entry_t                                     rom_q, rom_d;
  logic                                           rsp_valid_q, rsp_valid_d;
  logic [2:0]                                     rsp_status_q, rsp_status_d;
  logic [DATA_W-1:0]                              rsp_data_q, rsp_data_d;
  prm_entry_t                                     rsp_entry_q, rsp_entry_d;
  logic [CH_COUNT-1:0][PRM_COUNT-1:0]             exec_q, exec_d;
  logic [CH_COUNT-1:0][PRM_COUNT-1:0][DATA_W-1:0] values_q, values_d;

  logic [IW-1:0]  rom_addr;
  logic [IW-1:0]  addr_idx;
  logic [CIW-1:0] ch_idx;
  logic           req_rdy;
  prm_status_t    chk_status;

  assign addr_idx = addr_q[IW-1:0];
  assign ch_idx   = ch_q[CIW-1:0];
  assign req_rdy  = (state_q == S_IDLE) && init_done_q;

  // The ROM never sees an out-of-range address; such requests read entry 0 harmlessly.
  always_comb begin
    rom_addr = '0;
    if (state_q == S_INIT)
      rom_addr = init_cnt_q[ICW-1:1];
    else if (state_q == S_FETCH && addr_q < ADDR_LIM)
      rom_addr = addr_q[IW-1:0];
    rom_d = rom_lookup(rom_addr);
  end

  // Checks in priority order; evaluated in CHECK while rom_q holds the addressed entry.
  always_comb begin
    chk_status = ST_OK;
    if (addr_q >= ADDR_LIM)
      chk_status = ST_BAD_ADDR;
    else if (ch_q >= CH_LIM)
      chk_status = ST_BAD_CH;
    else begin
      case (op_q)
        OP_READ:  if (rom_q.rights == PRM_WO) chk_status = ST_DENIED;
        OP_WRITE: begin
          if (rom_q.rights == PRM_RO || rom_q.is_exec)
            chk_status = ST_DENIED;
          else if (data_q < DATA_W'(rom_q.min_val) || data_q > DATA_W'(rom_q.max_val))
            chk_status = ST_RANGE;
        end
        OP_EXEC:  if (!rom_q.is_exec) chk_status = ST_DENIED;
        default:  ;
      endcase
    end
  end

  always_comb begin
    state_d      = state_q;
    init_cnt_d   = init_cnt_q;
    init_done_d  = init_done_q;
    op_d         = op_q;
    ch_d         = ch_q;
    addr_d       = addr_q;
    data_d       = data_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_status_d = rsp_status_q;
    rsp_data_d   = rsp_data_q;
    rsp_entry_d  = rsp_entry_q;
    values_d     = values_q;
    exec_d       = '0;
    case (state_q)
      S_INIT: begin
        // Even count: ROM address cycle; odd count: write that entry's min to every channel.
        init_cnt_d = init_cnt_q + 1'b1;
        if (init_cnt_q[0]) begin
          for (int c = 0; c < CH_COUNT; c++)
            values_d[c][init_cnt_q[ICW-1:1]] = DATA_W'(rom_q.min_val);
        end
        if (init_cnt_q == INIT_LAST) begin
          state_d     = S_IDLE;
          init_done_d = 1'b1;
          init_cnt_d  = '0;
        end
      end
      S_IDLE: begin
        if (bus.req_valid && req_rdy) begin
          op_d    = bus.req_op;
          ch_d    = bus.req_ch;
          addr_d  = bus.req_addr;
          data_d  = bus.req_data;
          state_d = S_FETCH;
        end
      end
      S_FETCH: state_d = S_CHECK;
      S_CHECK: begin
        rsp_valid_d  = 1'b1;
        rsp_status_d = chk_status;
        rsp_data_d   = '0;
        rsp_entry_d  = '0;
        if (chk_status == ST_OK) begin
          rsp_entry_d = rom_q;
          case (op_q)
            // Exec parameters hold no value and always read back as zero.
            OP_READ:  if (!rom_q.is_exec) rsp_data_d = values_q[ch_idx][addr_idx];
            OP_WRITE: values_d[ch_idx][addr_idx] = data_q;
            OP_EXEC:  exec_d[ch_idx][addr_idx] = 1'b1;
            default:  ;
          endcase
        end
        state_d = S_RESP;
      end
      S_RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d  = 1'b0;
          rsp_status_d = '0;
          rsp_data_d   = '0;
          rsp_entry_d  = '0;
          state_d      = S_IDLE;
        end
      end
      default: state_d = S_INIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_INIT;
      init_cnt_q   <= '0;
      init_done_q  <= 1'b0;
      op_q         <= '0;
      ch_q         <= '0;
      addr_q       <= '0;
      data_q       <= '0;
      rom_q        <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_status_q <= '0;
      rsp_data_q   <= '0;
      rsp_entry_q  <= '0;
      exec_q       <= '0;
      values_q     <= '0;
    end else begin
      state_q      <= state_d;
      init_cnt_q   <= init_cnt_d;
      init_done_q  <= init_done_d;
      op_q         <= op_d;
      ch_q         <= ch_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      rom_q        <= rom_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_status_q <= rsp_status_d;
      rsp_data_q   <= rsp_data_d;
      rsp_entry_q  <= rsp_entry_d;
      exec_q       <= exec_d;
      values_q     <= values_d;
    end
  end

  assign bus.req_ready  = req_rdy;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_status = rsp_status_q;
  assign bus.rsp_data   = rsp_data_q;
  assign bus.rsp_entry  = rsp_entry_q;
  assign exec_pulse     = exec_q;
  assign values         = values_q;
  assign init_done      = init_done_q;

endmodule

// File: tb/tb_p10_prm_regfile.sv
// Bench for p10_prm_regfile: directed requests, expected responses queued at issue time,
// a negedge monitor pops and compares on every response handshake and checks latency.
module tb_p10_prm_regfile;
  import p10_pkg_common::*;

  localparam logic [1:0] OPR = 2'd0, OPW = 2'd1, OPE = 2'd2, OPI = 2'd3;
  localparam logic [2:0] OK = 3'd0, BADA = 3'd1, BADC = 3'd2, DEN = 3'd3, RNG = 3'd4;

  typedef struct {
    logic [2:0]  st;
    logic [31:0] dat;
    logic [1:0]  em;    // 0: entry not checked, 1: entry must be zero, 2: check max/units
    logic [31:0] emax;
    logic [23:0] eu;
  } exp_t;

  logic clk, rst_n;
  logic [15:0]  exec_pulse;
  logic [511:0] values;
  logic         init_done;

  p10_prm_regfile_if #(.PRM_COUNT(8), .CH_COUNT(2), .DATA_W(32)) bus ();

  p10_prm_regfile #(.PRM_COUNT(8), .CH_COUNT(2), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .exec_pulse(exec_pulse), .values(values), .init_done(init_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   acc_cyc = 0;
  logic prev_vld = 1'b0;
  exp_t sb[$];
  exp_t me;
  int   pulse_cnt;
  logic [15:0] pulse_val;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h required %0h", nm, act, req);
    end
  endtask

  task automatic fail_note(input string nm);
    total++;
    bad++;
    $display("FAIL %s: got no event within budget, required one", nm);
  endtask

  function automatic exp_t mk_exp(input logic [2:0] st, input logic [31:0] dat,
                                  input logic [1:0] em, input logic [31:0] emax,
                                  input logic [23:0] eu);
    exp_t e;
    e.st = st; e.dat = dat; e.em = em; e.emax = emax; e.eu = eu;
    return e;
  endfunction

  function automatic logic [31:0] val(input int c, input int p);
    return values[(c*8+p)*32 +: 32];
  endfunction

  // Monitor: latency on each rising rsp_valid, scoreboard compare on each handshake.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_vld = 1'b0;
    end else begin
      if (bus.req_valid && bus.req_ready) acc_cyc = cyc;
      if (bus.rsp_valid && !prev_vld) chk("rsp_latency", 64'(cyc - acc_cyc), 64'd3);
      prev_vld = bus.rsp_valid;
      if (bus.rsp_valid && bus.rsp_ready) begin
        if (sb.size() == 0) begin
          fail_note("unexpected_rsp");
        end else begin
          me = sb.pop_front();
          chk("rsp_status", 64'(bus.rsp_status), 64'(me.st));
          chk("rsp_data", 64'(bus.rsp_data), 64'(me.dat));
          if (me.em == 2'd1) chk("rsp_entry_zero", 64'(bus.rsp_entry == '0), 64'd1);
          if (me.em == 2'd2) begin
            chk("rsp_entry_max", 64'(bus.rsp_entry.max_val), 64'(me.emax));
            chk("rsp_entry_units", 64'(bus.rsp_entry.units), 64'(me.eu));
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] op, input logic [1:0] ch, input logic [3:0] addr,
                       input logic [31:0] data, input exp_t e);
    int n = 0;
    sb.push_back(e);
    bus.req_op = op; bus.req_ch = ch; bus.req_addr = addr; bus.req_data = data;
    bus.req_valid = 1'b1;
    while (!bus.req_ready && n < 40) begin tick(); n++; end
    if (!bus.req_ready) begin
      fail_note("accept_timeout");
      bus.req_valid = 1'b0;
      sb.delete();
    end else begin
      tick();
      bus.req_valid = 1'b0;
    end
  endtask

  task automatic wait_rsp();
    int n = 0;
    pulse_cnt = 0;
    pulse_val = '0;
    while (sb.size() != 0 && n < 40) begin
      tick(); n++;
      if (exec_pulse != '0) begin pulse_cnt++; pulse_val = exec_pulse; end
    end
    if (sb.size() != 0) begin fail_note("rsp_timeout"); sb.delete(); end
    repeat (2) begin
      tick();
      if (exec_pulse != '0) begin pulse_cnt++; pulse_val = exec_pulse; end
    end
  endtask

  task automatic req(input logic [1:0] op, input logic [1:0] ch, input logic [3:0] addr,
                     input logic [31:0] data, input logic [2:0] st, input logic [31:0] dat,
                     input logic [1:0] em, input logic [31:0] emax, input logic [23:0] eu);
    issue(op, ch, addr, data, mk_exp(st, dat, em, emax, eu));
    wait_rsp();
  endtask

  initial begin
    int n;
    int k;
    int acc[3];
    prm_entry_t snap;
    rst_n = 1'b0;
    bus.req_valid = 1'b0; bus.req_op = '0; bus.req_ch = '0; bus.req_addr = '0;
    bus.req_data = '0; bus.rsp_ready = 1'b1;
    repeat (3) tick();
    chk("rst_init_done", 64'(init_done), 64'd0);
    chk("rst_req_ready", 64'(bus.req_ready), 64'd0);
    chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("rst_values_zero", 64'(values == '0), 64'd1);
    chk("rst_exec_pulse", 64'(exec_pulse), 64'd0);

    // Init walk: 16 cycles after release.
    rst_n = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      tick();
      if (i == 15) chk("init_done_c15", 64'(init_done), 64'd0);
      if (i == 16) chk("init_done_c16", 64'(init_done), 64'd1);
    end
    for (int c = 0; c < 2; c++)
      for (int p = 0; p < 3; p++)
        chk("init_min_zero", 64'(val(c, p)), 64'd0);
    chk("init_deadtime_ch1", 64'(val(1, 3)), 64'd10);
    chk("init_fw_ver_ch0", 64'(val(0, 4)), 64'd258);

    // Writes and range checks, including both boundaries.
    req(OPW, 2'd1, 4'd1, 32'd50, OK, 32'd0, 2'd2, 32'd50, "pct");
    chk("duty_ch1", 64'(val(1, 1)), 64'd50);
    chk("duty_ch0", 64'(val(0, 1)), 64'd0);
    req(OPW, 2'd1, 4'd1, 32'd51, RNG, 32'd0, 2'd1, 32'd0, 24'd0);
    chk("duty_after_range", 64'(val(1, 1)), 64'd50);
    req(OPW, 2'd0, 4'd0, 32'd100000, OK, 32'd0, 2'd2, 32'd100000, "Hz ");
    chk("freq_at_max", 64'(val(0, 0)), 64'd100000);
    req(OPW, 2'd0, 4'd3, 32'd10, OK, 32'd0, 2'd2, 32'd1000, "ns ");
    req(OPW, 2'd0, 4'd3, 32'd9, RNG, 32'd0, 2'd1, 32'd0, 24'd0);
    chk("deadtime_below_min", 64'(val(0, 3)), 64'd10);

    // Address, channel and rights checks.
    req(OPW, 2'd0, 4'd9, 32'd5, BADA, 32'd0, 2'd1, 32'd0, 24'd0);
    req(OPI, 2'd0, 4'd8, 32'd0, BADA, 32'd0, 2'd1, 32'd0, 24'd0);
    req(OPW, 2'd2, 4'd1, 32'd5, BADC, 32'd0, 2'd1, 32'd0, 24'd0);
    req(OPR, 2'd0, 4'd4, 32'd0, OK, 32'd258, 2'd2, 32'd258, "ver");
    req(OPW, 2'd0, 4'd4, 32'd258, DEN, 32'd0, 2'd1, 32'd0, 24'd0);
    req(OPR, 2'd0, 4'd5, 32'd0, DEN, 32'd0, 2'd1, 32'd0, 24'd0);
    req(OPR, 2'd1, 4'd1, 32'd0, OK, 32'd50, 2'd2, 32'd50, "pct");

    // Exec strobes.
    req(OPE, 2'd0, 4'd6, 32'd0, OK, 32'd0, 2'd2, 32'd0, "   ");
    chk("exec_start_cnt", 64'(pulse_cnt), 64'd1);
    chk("exec_start_bit", 64'(pulse_val), 64'h0040);
    req(OPE, 2'd1, 4'd7, 32'd0, OK, 32'd0, 2'd2, 32'd0, "   ");
    chk("exec_stop_ch1_cnt", 64'(pulse_cnt), 64'd1);
    chk("exec_stop_ch1_bit", 64'(pulse_val), 64'h8000);
    req(OPE, 2'd0, 4'd0, 32'd0, DEN, 32'd0, 2'd1, 32'd0, 24'd0);
    chk("exec_freq_no_pulse", 64'(pulse_cnt), 64'd0);
    req(OPR, 2'd0, 4'd6, 32'd0, OK, 32'd0, 2'd2, 32'd0, "   ");
    req(OPW, 2'd0, 4'd7, 32'd0, DEN, 32'd0, 2'd1, 32'd0, 24'd0);

    // INFO ignores rights and returns only metadata.
    req(OPI, 2'd0, 4'd2, 32'd0, OK, 32'd0, 2'd2, 32'd359, "deg");
    req(OPI, 2'd1, 4'd5, 32'd7, OK, 32'd0, 2'd2, 32'd65535, "   ");

    // Back-to-back READs with rsp_ready held high.
    for (int i = 0; i < 3; i++) sb.push_back(mk_exp(OK, 32'd50, 2'd2, 32'd50, "pct"));
    bus.req_op = OPR; bus.req_ch = 2'd1; bus.req_addr = 4'd1; bus.req_data = '0;
    bus.req_valid = 1'b1;
    n = 0; k = 0;
    while (k < 3 && n < 60) begin
      if (bus.req_ready) begin acc[k] = cyc; k++; end
      tick(); n++;
    end
    bus.req_valid = 1'b0;
    chk("b2b_accepts", 64'(k), 64'd3);
    if (k == 3) begin
      chk("b2b_gap_1", 64'(acc[1] - acc[0]), 64'd4);
      chk("b2b_gap_2", 64'(acc[2] - acc[1]), 64'd4);
    end
    wait_rsp();

    // Response stall: fields stable and no accept while rsp_ready is low.
    bus.rsp_ready = 1'b0;
    issue(OPR, 2'd1, 4'd1, 32'd0, mk_exp(OK, 32'd50, 2'd2, 32'd50, "pct"));
    n = 0;
    while (!bus.rsp_valid && n < 20) begin tick(); n++; end
    if (!bus.rsp_valid) fail_note("stall_rsp_valid");
    snap = bus.rsp_entry;
    bus.req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_rsp_valid", 64'(bus.rsp_valid), 64'd1);
      chk("stall_req_ready", 64'(bus.req_ready), 64'd0);
      chk("stall_status", 64'(bus.rsp_status), 64'(OK));
      chk("stall_data", 64'(bus.rsp_data), 64'd50);
      chk("stall_entry", 64'(bus.rsp_entry == snap), 64'd1);
    end
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    wait_rsp();

    // Reset while the request sits in FETCH.
    issue(OPR, 2'd0, 4'd0, 32'd0, mk_exp(OK, 32'd100000, 2'd2, 32'd100000, "Hz "));
    rst_n = 1'b0;
    #1;
    chk("midrst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    tick();
    chk("midrst_init_done", 64'(init_done), 64'd0);
    chk("midrst_freq_clear", 64'(val(0, 0)), 64'd0);
    chk("midrst_duty_clear", 64'(val(1, 1)), 64'd0);
    sb.delete();
    rst_n = 1'b1;
    repeat (16) tick();
    chk("rerun_init_done", 64'(init_done), 64'd1);
    chk("rerun_deadtime", 64'(val(0, 3)), 64'd10);
    req(OPR, 2'd0, 4'd0, 32'd0, OK, 32'd0, 2'd2, 32'd100000, "Hz ");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
